// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Routes one of NUM_CHANNELS same-clock UART TX lines onto the board TXD pin.
//   A change of 'sel' is deferred until both the outgoing and the incoming line
//   have been idle (mark) for IDLE_CYCLES = IDLE_BITS * BAUD_PERIOD cycles, so a
//   switch never truncates a character or starts mid-character.
//
//   Optional feature, enabled by defining UART_TX_ARB_FORCE_SWITCH_EN:
//   if a switch has been pending for FORCE_TIMEOUT cycles, the switch is forced,
//   'forced' pulses, and TXD is held at mark for IDLE_CYCLES cycles before the
//   new source is routed. Without the macro a busy channel blocks switching.
//
// Ports
//   clk            system clock
//   reset_n        asynchronous reset, active low
//   sync_reset     synchronous reset, active high (same effect as reset_n)
//   tx_in          UART TX line per source, idle high
//   sel            requested channel, level sensitive
//   TXD            registered UART output to the pad
//   sel_active     channel currently routed
//   switch_pending high while a requested switch is waiting or executing
//   sel_error      one-cycle pulse when an out-of-range sel is first seen
//   forced         one-cycle pulse on a forced switch (0 without the feature)

module uart_tx_arbiter #(
    parameter int unsigned NUM_CHANNELS  = 2,
    parameter int unsigned SEL_WIDTH     = 1,
    parameter int unsigned BAUD_PERIOD   = 868,
    parameter int unsigned IDLE_BITS     = 11,
    parameter int unsigned FORCE_TIMEOUT = 1000000
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    sync_reset,
    input  logic [NUM_CHANNELS-1:0] tx_in,
    input  logic [SEL_WIDTH-1:0]    sel,
    output logic                    TXD,
    output logic [SEL_WIDTH-1:0]    sel_active,
    output logic                    switch_pending,
    output logic                    sel_error,
    output logic                    forced
);

    localparam int unsigned IDLE_CYCLES = IDLE_BITS * BAUD_PERIOD;
    localparam int unsigned CNT_W       = $clog2(IDLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(IDLE_CYCLES);
    // The forcing cycle itself already drives mark, so GAP lasts one cycle less
    // than IDLE_CYCLES to give exactly IDLE_CYCLES mark cycles on TXD.
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((IDLE_CYCLES > 1) ? IDLE_CYCLES - 2 : 0);

    // Elaboration-time parameter checks
    if (NUM_CHANNELS < 2 || NUM_CHANNELS > 16) begin : g_bad_num_channels
        $error("NUM_CHANNELS must be in 2..16");
    end
    if ((64'd1 << SEL_WIDTH) < 64'(NUM_CHANNELS)) begin : g_bad_sel_width
        $error("SEL_WIDTH too small for NUM_CHANNELS");
    end
    if (IDLE_CYCLES < 1) begin : g_bad_idle
        $error("IDLE_BITS * BAUD_PERIOD must be at least 1");
    end
    if (FORCE_TIMEOUT < 1) begin : g_bad_timeout
        $error("FORCE_TIMEOUT must be at least 1");
    end

`ifdef UART_TX_ARB_FORCE_SWITCH_EN
    typedef enum logic [1:0] {StNormal, StPending, StSwitch, StGap} state_e;
    localparam int unsigned TMR_W = $clog2(FORCE_TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(FORCE_TIMEOUT - 1);
`else
    typedef enum logic [1:0] {StNormal, StPending, StSwitch} state_e;
`endif

    state_e                  state_q, state_d;
    logic [SEL_WIDTH-1:0]    sel_active_q, sel_active_d;
    logic [SEL_WIDTH-1:0]    target_q, target_d;
    logic                    txd_q, txd_d;
    logic                    sel_error_q, sel_error_d;
    logic                    err_seen_q, err_seen_d;
    logic [SEL_WIDTH-1:0]    err_sel_q, err_sel_d;

    logic [CNT_W-1:0]        idle_cnt_q [NUM_CHANNELS];
    logic [CNT_W-1:0]        idle_cnt_d [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] quiet;

    logic                    active_line;
    logic                    active_quiet;
    logic                    target_quiet;
    logic                    sel_illegal;

`ifdef UART_TX_ARB_FORCE_SWITCH_EN
    logic [TMR_W-1:0]        timer_q, timer_d;
    logic [CNT_W-1:0]        gap_q, gap_d;
    logic                    forced_q, forced_d;
`endif

    // ------------------------------------------------------------------
    // Per-channel saturating idle counters
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            idle_cnt_d[i] = idle_cnt_q[i];
            if (sync_reset || !tx_in[i]) begin
                idle_cnt_d[i] = '0;
            end else if (idle_cnt_q[i] != CNT_MAX) begin
                idle_cnt_d[i] = idle_cnt_q[i] + CNT_W'(1);
            end
            // Qualified with the live level: a line that falls in the very cycle
            // the switch would be taken is not treated as quiet.
            quiet[i] = (idle_cnt_q[i] == CNT_MAX) && tx_in[i];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                idle_cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                idle_cnt_q[i] <= idle_cnt_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Channel selection helpers (compare loops avoid over-wide indices)
    // ------------------------------------------------------------------
    always_comb begin
        active_line  = 1'b1;
        active_quiet = 1'b0;
        target_quiet = 1'b0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (sel_active_q == SEL_WIDTH'(i)) begin
                active_line  = tx_in[i];
                active_quiet = quiet[i];
            end
            if (sel == SEL_WIDTH'(i)) begin
                target_quiet = quiet[i];
            end
        end
    end

    assign sel_illegal = (32'(sel) >= NUM_CHANNELS);

    // ------------------------------------------------------------------
    // Control FSM: next state and registered outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        sel_active_d = sel_active_q;
        target_d     = target_q;
        txd_d        = active_line;
        sel_error_d  = 1'b0;
        err_seen_d   = err_seen_q;
        err_sel_d    = err_sel_q;
`ifdef UART_TX_ARB_FORCE_SWITCH_EN
        timer_d      = '0;
        gap_d        = gap_q;
        forced_d     = 1'b0;
`endif

        // A legal sel re-arms the error pulse.
        if (!sel_illegal) begin
            err_seen_d = 1'b0;
        end

        unique case (state_q)
            StNormal: begin
                if (sel_illegal) begin
                    if (!err_seen_q || (sel != err_sel_q)) begin
                        sel_error_d = 1'b1;
                        err_seen_d  = 1'b1;
                        err_sel_d   = sel;
                    end
                end else if (sel != sel_active_q) begin
                    state_d = StPending;
                end
            end

            StPending: begin
                // The target is the live sel; target_q only carries it into SWITCH.
                if (sel_illegal || (sel == sel_active_q)) begin
                    state_d = StNormal;
                end else if (active_quiet && target_quiet) begin
                    state_d  = StSwitch;
                    target_d = sel;
                end
`ifdef UART_TX_ARB_FORCE_SWITCH_EN
                else if (timer_q == TMR_LAST) begin
                    state_d      = StGap;
                    sel_active_d = sel;
                    forced_d     = 1'b1;
                    txd_d        = 1'b1;
                    gap_d        = '0;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
`endif
            end

            StSwitch: begin
                sel_active_d = target_q;
                txd_d        = 1'b1;
                state_d      = StNormal;
            end

`ifdef UART_TX_ARB_FORCE_SWITCH_EN
            StGap: begin
                // Hold mark so the receiver resynchronises; sel is ignored here.
                txd_d = 1'b1;
                if (gap_q == GAP_LAST) begin
                    state_d = StNormal;
                end else begin
                    gap_d = gap_q + CNT_W'(1);
                end
            end
`endif

            default: begin
                state_d = StNormal;
            end
        endcase

        if (sync_reset) begin
            state_d      = StNormal;
            sel_active_d = '0;
            target_d     = '0;
            txd_d        = 1'b1;
            sel_error_d  = 1'b0;
            err_seen_d   = 1'b0;
            err_sel_d    = '0;
`ifdef UART_TX_ARB_FORCE_SWITCH_EN
            timer_d      = '0;
            gap_d        = '0;
            forced_d     = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StNormal;
            sel_active_q <= '0;
            target_q     <= '0;
            txd_q        <= 1'b1;
            sel_error_q  <= 1'b0;
            err_seen_q   <= 1'b0;
            err_sel_q    <= '0;
        end else begin
            state_q      <= state_d;
            sel_active_q <= sel_active_d;
            target_q     <= target_d;
            txd_q        <= txd_d;
            sel_error_q  <= sel_error_d;
            err_seen_q   <= err_seen_d;
            err_sel_q    <= err_sel_d;
        end
    end

`ifdef UART_TX_ARB_FORCE_SWITCH_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timer_q  <= '0;
            gap_q    <= '0;
            forced_q <= 1'b0;
        end else begin
            timer_q  <= timer_d;
            gap_q    <= gap_d;
            forced_q <= forced_d;
        end
    end

    assign forced = forced_q;
`else
    assign forced = 1'b0;
`endif

    assign TXD            = txd_q;
    assign sel_active     = sel_active_q;
    assign switch_pending = (state_q == StPending) || (state_q == StSwitch);
    assign sel_error      = sel_error_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
//   Self-checking bench for uart_tx_arbiter. Two instances share clock, resets
//   and TX lines: 'dut' (4 channels, 2-bit sel) and 'dut3' (4 channels, 3-bit
//   sel) for out-of-range select handling. Expected TXD values are pushed to a
//   queue when the inputs are driven and popped one cycle later.

module tb_uart_tx_arbiter;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       sync_reset = 1'b0;
    logic [3:0] tx_in = 4'hF;
    logic [1:0] sel = 2'd0;
    logic [2:0] sel3 = 3'd0;

    logic       txd, txd3;
    logic [1:0] sel_active;
    logic [2:0] sel_active3;
    logic       pend, pend3, serr, serr3, frc, frc3;

    int checks = 0;
    int errors = 0;
    bit exp_txd_q[$];

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_CHANNELS (4),
        .SEL_WIDTH    (2),
        .BAUD_PERIOD  (4),
        .IDLE_BITS    (2),
        .FORCE_TIMEOUT(50)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .sync_reset    (sync_reset),
        .tx_in         (tx_in),
        .sel           (sel),
        .TXD           (txd),
        .sel_active    (sel_active),
        .switch_pending(pend),
        .sel_error     (serr),
        .forced        (frc)
    );

    uart_tx_arbiter #(
        .NUM_CHANNELS (4),
        .SEL_WIDTH    (3),
        .BAUD_PERIOD  (4),
        .IDLE_BITS    (2),
        .FORCE_TIMEOUT(50)
    ) dut3 (
        .clk           (clk),
        .reset_n       (reset_n),
        .sync_reset    (sync_reset),
        .tx_in         (tx_in),
        .sel           (sel3),
        .TXD           (txd3),
        .sel_active    (sel_active3),
        .switch_pending(pend3),
        .sel_error     (serr3),
        .forced        (frc3)
    );

    // Outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tx_in = 4'hF; sel = 2'd0; sel3 = 3'd0; reset_n = 1'b0;
        repeat (3) tick();
        checks++; if (txd !== 1'b1) begin errors++; $display("FAIL reset_txd got %b want 1", txd); end
        checks++; if (sel_active !== 2'd0) begin errors++; $display("FAIL reset_sel_active got %0d want 0", sel_active); end
        checks++; if ({pend, serr, frc} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {pend, serr, frc}); end
        checks++; if ({txd3, sel_active3, pend3, serr3, frc3} !== 7'b1000000) begin
            errors++; $display("FAIL reset_dut3 got %b want 1000000", {txd3, sel_active3, pend3, serr3, frc3});
        end
        reset_n = 1'b1;
        tick();
        checks++; if ({txd, sel_active, pend} !== 4'b1000) begin
            errors++; $display("FAIL reset_release got %b want 1000", {txd, sel_active, pend});
        end
    endtask

    // Channel 0 toggles 1,0,1; other channels wiggle but must not be routed.
    task automatic test_follow();
        logic [3:0] pat [7] = '{4'b1111, 4'b1110, 4'b1111, 4'b0001, 4'b1010, 4'b0101, 4'b1111};
        for (int k = 0; k < 7; k++) begin
            tx_in = pat[k];
            exp_txd_q.push_back(pat[k][0]);
            tick();
            begin
                bit e;
                e = exp_txd_q.pop_front();
                checks++; if (txd !== e) begin errors++; $display("FAIL follow_txd step %0d got %b want %b", k, txd, e); end
            end
            checks++; if (sel_active !== 2'd0) begin errors++; $display("FAIL follow_sel_active step %0d got %0d want 0", k, sel_active); end
        end
    endtask

    task automatic test_switch();
        tx_in = 4'hF;
        repeat (10) tick();
        sel = 2'd2;
        tick();  // PENDING
        checks++; if ({pend, sel_active} !== {1'b1, 2'd0}) begin
            errors++; $display("FAIL switch_pending1 got pend=%b act=%0d want pend=1 act=0", pend, sel_active);
        end
        tick();  // SWITCH
        checks++; if ({pend, sel_active, txd} !== {1'b1, 2'd0, 1'b1}) begin
            errors++; $display("FAIL switch_state got pend=%b act=%0d txd=%b want 1/0/1", pend, sel_active, txd);
        end
        tick();  // NORMAL
        checks++; if ({pend, sel_active, txd} !== {1'b0, 2'd2, 1'b1}) begin
            errors++; $display("FAIL switch_done got pend=%b act=%0d txd=%b want 0/2/1", pend, sel_active, txd);
        end
    endtask

    // 10-bit frame (start, 0xA5 LSB first, stop) at 4 cycles/bit on channel 0
    // while sel asks for channel 1.
    task automatic test_frame();
        logic [9:0] bits;
        logic       f [54];
        int         last_low;
        bits = {1'b1, 8'hA5, 1'b0};
        // sync_reset takes the active channel from 2 back to 0
        sync_reset = 1'b1; sel = 2'd0;
        tick();
        sync_reset = 1'b0;
        checks++; if ({sel_active, pend, txd} !== {2'd0, 1'b0, 1'b1}) begin
            errors++; $display("FAIL sync_reset got act=%0d pend=%b txd=%b want 0/0/1", sel_active, pend, txd);
        end
        repeat (10) tick();
        last_low = -1;
        for (int c = 0; c < 54; c++) begin
            f[c] = (c < 40) ? bits[c / 4] : 1'b1;
            if (!f[c]) last_low = c;
        end
        for (int c = 0; c < 54; c++) begin
            tx_in = {3'b111, f[c]};
            sel   = 2'd1;
            // Counter reaches 8 in cycle last_low+9 -> SWITCH at +10 -> routed at +11
            if (c < last_low + 10) exp_txd_q.push_back(f[c]);
            else                   exp_txd_q.push_back(1'b1);
            tick();
            begin
                bit       e;
                bit [1:0] ea;
                e  = exp_txd_q.pop_front();
                ea = (c + 1 >= last_low + 11) ? 2'd1 : 2'd0;
                checks++; if (txd !== e) begin errors++; $display("FAIL frame_txd cycle %0d got %b want %b", c + 1, txd, e); end
                checks++; if (sel_active !== ea) begin
                    errors++; $display("FAIL frame_sel_active cycle %0d got %0d want %0d", c + 1, sel_active, ea);
                end
            end
        end
    endtask

    task automatic test_sel_error();
        tx_in = 4'hF;
        repeat (10) tick();
        sel3 = 3'd3;
        repeat (3) tick();
        checks++; if (sel_active3 !== 3'd3) begin errors++; $display("FAIL err_setup_active got %0d want 3", sel_active3); end
        sel3 = 3'd5;
        tick();
        checks++; if ({serr3, pend3, sel_active3} !== {1'b1, 1'b0, 3'd3}) begin
            errors++; $display("FAIL err_pulse5 got serr=%b pend=%b act=%0d want 1/0/3", serr3, pend3, sel_active3);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++; if ({serr3, pend3, sel_active3} !== {1'b0, 1'b0, 3'd3}) begin
                errors++; $display("FAIL err_hold5 step %0d got serr=%b pend=%b act=%0d want 0/0/3", k, serr3, pend3, sel_active3);
            end
        end
        sel3 = 3'd6;
        tick();
        checks++; if (serr3 !== 1'b1) begin errors++; $display("FAIL err_pulse6 got %b want 1", serr3); end
        sel3 = 3'd3;
        tick();
        checks++; if ({serr3, pend3} !== 2'b00) begin errors++; $display("FAIL err_legal got %b want 00", {serr3, pend3}); end
        sel3 = 3'd5;
        tick();
        checks++; if (serr3 !== 1'b1) begin errors++; $display("FAIL err_rearm got %b want 1", serr3); end
        sel3 = 3'd0;
        tick();
    endtask

    task automatic test_async_reset();
        sync_reset = 1'b1; sel = 2'd0; sel3 = 3'd0;
        tick();
        sync_reset = 1'b0;
        tx_in = 4'b1100; sel = 2'd1;
        tick();
        tick();
        checks++; if ({pend, txd, sel_active} !== {1'b1, 1'b0, 2'd0}) begin
            errors++; $display("FAIL arst_setup got pend=%b txd=%b act=%0d want 1/0/0", pend, txd, sel_active);
        end
        #3 reset_n = 1'b0;
        #1;
        checks++; if ({txd, sel_active, pend, serr, frc} !== {1'b1, 2'd0, 3'b000}) begin
            errors++; $display("FAIL arst_async got %b want 100000", {txd, sel_active, pend, serr, frc});
        end
        sel = 2'd0; tx_in = 4'hF;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        checks++; if ({sel_active, pend, txd} !== {2'd0, 1'b0, 1'b1}) begin
            errors++; $display("FAIL arst_release got act=%0d pend=%b txd=%b want 0/0/1", sel_active, pend, txd);
        end
    endtask

    // Channel 0 stuck low while sel asks for channel 1; PENDING entered in cycle 1.
    task automatic test_force();
        for (int c = 0; c < 70; c++) begin
            int       o;
            bit       tx1, e, ef, ep;
            bit [1:0] ea;
            o   = c + 1;
            tx1 = (c >= 58) ? bit'(c % 2) : 1'b1;
            tx_in = {2'b11, tx1, 1'b0};
            sel   = 2'd1;
`ifdef UART_TX_ARB_FORCE_SWITCH_EN
            if (o <= 50)      e = 1'b0;
            else if (o <= 58) e = 1'b1;
            else              e = tx1;
            ef = (o == 51);
            ea = (o >= 51) ? 2'd1 : 2'd0;
            ep = (o <= 50);
`else
            e  = 1'b0;
            ef = 1'b0;
            ea = 2'd0;
            ep = 1'b1;
`endif
            exp_txd_q.push_back(e);
            tick();
            e = exp_txd_q.pop_front();
            checks++; if (txd !== e) begin errors++; $display("FAIL force_txd cycle %0d got %b want %b", o, txd, e); end
            checks++; if ({frc, sel_active, pend} !== {ef, ea, ep}) begin
                errors++; $display("FAIL force_state cycle %0d got frc=%b act=%0d pend=%b want %b/%0d/%b",
                                   o, frc, sel_active, pend, ef, ea, ep);
            end
        end
    endtask

    initial begin
        test_reset();
        test_follow();
        test_switch();
        test_frame();
        test_sel_error();
        test_async_reset();
        test_force();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
